// File: rtl/vm1_bus_pkg.sv
// VM1 bus unit shared definitions.
// State encoding, trap vector and byte-enable helpers.
package vm1_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } bus_state_e;

  localparam logic [15:0] TRAP_BUS = 16'o000004;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic [1:0] be_sel(
    input logic byte_acc,
    input logic a0
  );
    if (!byte_acc) return BE_WORD;
    return a0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/vm1_bus_timeout.sv
// Reply-timeout counter for the VM1 bus unit.
// Loadable up-counter with clear and terminal-count flag.
module vm1_bus_timeout #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (ld) cnt_d = ld_val;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // flags the cycle whose increment reaches TIMEOUT-1
  assign tc = (cnt_q == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/vm1_bus_unit.sv
// VM1 bus interface stage: strobe/ack handshake,
// datapath stall, odd-address and timeout bus errors.
module vm1_bus_unit
  import vm1_bus_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] dba,
  input  logic [15:0] dbo,
  output logic [15:0] dbi,
  output logic        ce,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  bus_state_e  state_q, state_d;
  logic [15:0] dbi_q, dbi_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic        cnt_clr, cnt_en, cnt_tc;
  logic        req_any;

  assign req_any = req_rd | req_wr;

  vm1_bus_timeout #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ld    (1'b0),
    .ld_val('0),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    dbi_d   = dbi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (!req_byte && dba[0]) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            addr_d  = {dba[15:1], 1'b0};
            be_d    = be_sel(req_byte, dba[0]);
            cnt_clr = 1'b1;
            // read wins over a simultaneous write
            if (req_rd) begin
              state_d = S_RD;
              rd_d    = 1'b1;
            end else begin
              state_d = S_WR;
              wr_d    = 1'b1;
              wdata_d = req_byte ? {dbo[7:0], dbo[7:0]} : dbo;
            end
          end
        end
      end
      S_RD, S_WR: begin
        cnt_en = 1'b1;
        if (mem_ack) begin
          state_d = S_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == S_RD) dbi_d = mem_rdata;
        end else if (cnt_tc) begin
          state_d = S_ERR;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dbi_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbi_q   <= dbi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign ce = (state_q == S_IDLE && !req_any) ||
              (state_q == S_DONE) ||
              (state_q == S_ERR);

  assign dbi       = dbi_q;
  assign bus_err   = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;

endmodule

// File: tb/tb_vm1_bus_unit.sv
// Randomised transaction-level bench for vm1_bus_unit
// against an access-level reference model.
module tb_vm1_bus_unit;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] dba = '0;
  logic [15:0] dbo = '0;
  logic [15:0] dbi;
  logic        ce;
  logic        bus_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  logic        idle_noise = 1'b0;
  logic [15:0] model_dbi = '0;

  vm1_bus_unit #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_byte (req_byte),
    .dba      (dba),
    .dbo      (dbo),
    .dbi      (dbi),
    .ce       (ce),
    .bus_err  (bus_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  // slave: acks after ack_dly wait cycles; random ack noise when idle
  always @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= 0;
    else if (mem_rd | mem_wr) wait_cnt <= wait_cnt + 1;
    else                      wait_cnt <= 0;
  end

  always @(negedge clk) idle_noise <= 1'($urandom_range(0, 1));

  assign mem_ack = (mem_rd | mem_wr) ? (wait_cnt == ack_dly) : idle_noise;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && req_rd && req_wr) begin
      chk("rd_wins", {31'b0, mem_wr}, 32'd0);
      a_rd_wins: assert (!mem_wr);
    end
  end

  // one access; entered just after a rising edge, leaves just after one
  task automatic run_txn(input bit rd, input bit wr, input bit byt,
                         input logic [15:0] a, input logic [15:0] d,
                         input int dly, input logic [15:0] rdat);
    bit odd, to, exp_err, seen_rd, seen_wr, got_err;
    int ns, nerr, ce_cyc, exp_ns;
    logic [15:0] f_addr, f_wd, exp_wd;
    logic [1:0]  f_be, exp_be;
    odd     = !byt && a[0];
    to      = !odd && (dly > TIMEOUT - 2);
    exp_ns  = odd ? 0 : (to ? TIMEOUT - 1 : dly + 1);
    exp_err = odd || to;
    exp_be  = !byt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    exp_wd  = byt ? {d[7:0], d[7:0]} : d;
    ns = 0; nerr = 0; ce_cyc = -1;
    seen_rd = 0; seen_wr = 0; got_err = 0;
    f_addr = '0; f_wd = '0; f_be = '0;
    ack_dly   = dly;
    mem_rdata = rdat;
    req_rd = rd; req_wr = wr; req_byte = byt; dba = a; dbo = d;
    for (int cyc = 0; cyc < 200 && ce_cyc < 0; cyc++) begin
      @(negedge clk);
      if (mem_rd | mem_wr) begin
        if (ns == 0) begin
          f_addr = mem_addr; f_be = mem_be; f_wd = mem_wdata;
        end
        ns++;
      end
      seen_rd |= mem_rd;
      seen_wr |= mem_wr;
      if (ce) begin
        ce_cyc  = cyc;
        got_err = bus_err;
      end else if (bus_err) nerr++;
    end
    chk("ce_seen", {31'b0, ce_cyc >= 0}, 32'd1);
    chk("latency", ce_cyc, exp_ns + 1);
    chk("strobes", ns, exp_ns);
    chk("bus_err", {31'b0, got_err}, {31'b0, exp_err});
    chk("err_early", nerr, 0);
    if (!odd) begin
      chk("kind", {30'b0, seen_rd, seen_wr}, rd ? 32'd2 : 32'd1);
      chk("addr", f_addr, {a[15:1], 1'b0});
      chk("be", f_be, exp_be);
      if (!rd) chk("wdata", f_wd, exp_wd);
    end else begin
      chk("no_stb", {30'b0, seen_rd, seen_wr}, 32'd0);
    end
    if (rd && !exp_err) model_dbi = rdat;
    @(posedge clk);
    #1;
    chk("dbi", dbi, model_dbi);
    req_rd = 0; req_wr = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_ce", {29'b0, ce, mem_rd, mem_wr}, 32'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, r, dly;
    bit byt;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ce", {31'b0, ce}, 32'd1);
    chk("rst_dbi", dbi, 32'd0);
    chk("rst_stb", {29'b0, mem_rd, mem_wr, bus_err}, 32'd0);
    chk("rst_addr", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_be", mem_be, 32'd0);
    @(posedge clk);
    #1;

    run_txn(1, 0, 0, 16'o001000, 16'h0, 0, 16'o123456);
    run_txn(0, 1, 1, 16'o001001, 16'h00A5, 3, 16'h0);
    run_txn(1, 0, 0, 16'o001003, 16'h0, 0, 16'h1111);
    run_txn(1, 0, 0, 16'o002000, 16'h0, 100, 16'hDEAD);
    run_txn(1, 0, 0, 16'o002000, 16'h0, TIMEOUT - 2, 16'hBEEF);
    run_txn(1, 0, 1, 16'o003005, 16'h0, 1, 16'h1234);
    run_txn(0, 1, 0, 16'o003006, 16'h5A5A, 0, 16'h0);
    run_txn(1, 1, 0, 16'o004000, 16'h7777, 2, 16'h4321);
    idle_cycle();

    for (int n = 0; n < 60; n++) begin
      k   = $urandom_range(0, 8);
      r   = $urandom_range(0, 19);
      byt = 1'($urandom_range(0, 1));
      dly = (r == 0) ? 100 : (r == 1) ? TIMEOUT - 2 : $urandom_range(0, 5);
      run_txn(k < 4 || k == 8, k >= 4, byt, 16'($urandom),
              16'($urandom), dly, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // reset in the middle of a write wait
    ack_dly = 100;
    req_wr = 1; req_byte = 0; dba = 16'h0100; dbo = 16'h1234;
    repeat (3) @(negedge clk);
    chk("pre_rst_wr", {31'b0, mem_wr}, 32'd1);
    #2 reset = 1;
    #1;
    chk("rst_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_ce_low", {30'b0, ce, bus_err}, 32'd0);
    @(posedge clk);
    #1 req_wr = 0; reset = 0;
    model_dbi = '0;
    @(negedge clk);
    chk("post_rst_ce", {31'b0, ce}, 32'd1);
    chk("post_rst_dbi", dbi, 32'd0);
    chk("post_rst_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    run_txn(1, 0, 0, 16'o000100, 16'h0, 1, 16'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
